control_sequencer: RTL and testbench

- Hard-wired control unit. It sequences every instruction as a Moore state machine through fetch (T0–T2) and execute (T3–T7) steps.
- It drives the register-select strobes (G_RA/G_RB/G_RC, R_In, R_Out, BA_Out) consumed by select-and-encode, plus all datapath, ALU and memory strobes.
- It reads the opcode from IR_Out and handshakes with memory through Mem_Ready.

---
 rtl/control_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit: fetch (T0-T2) and execute (T3-T7) sequencing.
// Every strobe is decoded from the state register and the opcode field of IR_Out.
module control_sequencer #(
    parameter int OPW = 5
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    IR_Out,
    input  logic           CON_FF,
    input  logic           Mem_Ready,
    output logic           PC_Out,
    output logic           PC_In,
    output logic           IncPC,
    output logic           MAR_In,
    output logic           MDR_In,
    output logic           MDR_Read,
    output logic           MDR_Out,
    output logic           IR_In,
    output logic           Y_In,
    output logic           Zlow_In,
    output logic           Zlow_Out,
    output logic           C_Out,
    output logic           Con_In,
    output logic           InPort_Out,
    output logic           OutPort_In,
    output logic           G_RA,
    output logic           G_RB,
    output logic           G_RC,
    output logic           R_In,
    output logic           R_Out,
    output logic           BA_Out,
    output logic           Mem_Read,
    output logic           Mem_Write,
    output logic [OPW-1:0] ALU_Op,
    output logic           Run,
    output logic           Illegal
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
    localparam logic [OPW-1:0] OP_HALT = 5'b11001;

    logic [3:0]     state_r;
    logic [3:0]     next_s;
    logic [OPW-1:0] op_s;
    logic           unused_ir_s;

    assign op_s        = IR_Out[31 -: OPW];
    // Register fields are consumed by select-and-encode, not here.
    assign unused_ir_s = ^IR_Out[31-OPW:0];

    // State register with asynchronous clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= S_RST;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state sequencing; Mem_Ready only matters in the three wait states.
    always_comb begin
        next_s = S_RST;
        case (state_r)
            S_RST: next_s = S_T0;
            S_T0:  next_s = S_T1;
            S_T1:  next_s = Mem_Ready ? S_T2 : S_T1;
            S_T2:  next_s = S_T3;
            S_T3: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI,
                    OP_LD, OP_LDI, OP_ST, OP_BR: next_s = S_T4;
                    OP_HALT:                     next_s = S_HALT;
                    default:                     next_s = S_T0;
                endcase
            end
            S_T4: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI,
                    OP_LD, OP_LDI, OP_ST, OP_BR: next_s = S_T5;
                    default:                     next_s = S_T0;
                endcase
            end
            S_T5: begin
                case (op_s)
                    OP_LD, OP_ST, OP_BR: next_s = S_T6;
                    default:             next_s = S_T0;
                endcase
            end
            S_T6: begin
                case (op_s)
                    OP_LD:   next_s = Mem_Ready ? S_T7 : S_T6;
                    OP_ST:   next_s = S_T7;
                    default: next_s = S_T0;
                endcase
            end
            S_T7: begin
                case (op_s)
                    OP_ST:   next_s = Mem_Ready ? S_T0 : S_T7;
                    default: next_s = S_T0;
                endcase
            end
            S_HALT:  next_s = S_HALT;
            default: next_s = S_RST;
        endcase
    end

    // Moore strobe decode; anything not named for a state stays low.
    always_comb begin
        PC_Out     = 1'b0;
        PC_In      = 1'b0;
        IncPC      = 1'b0;
        MAR_In     = 1'b0;
        MDR_In     = 1'b0;
        MDR_Read   = 1'b0;
        MDR_Out    = 1'b0;
        IR_In      = 1'b0;
        Y_In       = 1'b0;
        Zlow_In    = 1'b0;
        Zlow_Out   = 1'b0;
        C_Out      = 1'b0;
        Con_In     = 1'b0;
        InPort_Out = 1'b0;
        OutPort_In = 1'b0;
        G_RA       = 1'b0;
        G_RB       = 1'b0;
        G_RC       = 1'b0;
        R_In       = 1'b0;
        R_Out      = 1'b0;
        BA_Out     = 1'b0;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        ALU_Op     = '0;
        Illegal    = 1'b0;
        Run        = (state_r != S_RST) && (state_r != S_HALT);
        case (state_r)
            S_T0: begin
                PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; Zlow_In = 1'b1;
            end
            S_T1: begin
                Zlow_Out = 1'b1; PC_In = 1'b1; Mem_Read = 1'b1;
                MDR_Read = 1'b1; MDR_In = 1'b1;
            end
            S_T2: begin
                MDR_Out = 1'b1; IR_In = 1'b1;
            end
            S_T3: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        G_RB = 1'b1; R_Out = 1'b1; Y_In = 1'b1;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        G_RB = 1'b1; BA_Out = 1'b1; Y_In = 1'b1;
                    end
                    OP_BR:  begin G_RA = 1'b1; R_Out = 1'b1; Con_In = 1'b1; end
                    OP_JR:  begin G_RA = 1'b1; R_Out = 1'b1; PC_In = 1'b1; end
                    OP_IN:  begin InPort_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
                    OP_OUT: begin G_RA = 1'b1; R_Out = 1'b1; OutPort_In = 1'b1; end
                    OP_NOP, OP_HALT: ;
                    default: Illegal = 1'b1;
                endcase
            end
            S_T4: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        G_RC = 1'b1; R_Out = 1'b1; Zlow_In = 1'b1; ALU_Op = op_s;
                    end
                    OP_ADDI, OP_LD, OP_LDI, OP_ST: begin
                        C_Out = 1'b1; Zlow_In = 1'b1; ALU_Op = OP_ADD;
                    end
                    OP_ANDI: begin C_Out = 1'b1; Zlow_In = 1'b1; ALU_Op = OP_AND; end
                    OP_ORI:  begin C_Out = 1'b1; Zlow_In = 1'b1; ALU_Op = OP_OR; end
                    OP_BR:   begin PC_Out = 1'b1; Y_In = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        Zlow_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1;
                    end
                    OP_LD, OP_ST: begin Zlow_Out = 1'b1; MAR_In = 1'b1; end
                    OP_BR: begin C_Out = 1'b1; Zlow_In = 1'b1; ALU_Op = OP_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_s)
                    OP_LD: begin Mem_Read = 1'b1; MDR_Read = 1'b1; MDR_In = 1'b1; end
                    OP_ST: begin G_RA = 1'b1; R_Out = 1'b1; MDR_In = 1'b1; end
                    OP_BR: begin Zlow_Out = 1'b1; PC_In = CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_s)
                    OP_LD: begin MDR_Out = 1'b1; G_RA = 1'b1; R_In = 1'b1; end
                    OP_ST: Mem_Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected strobe
// vector for each cycle, a negedge monitor pops and compares it.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR_Out;
    logic        CON_FF;
    logic        Mem_Ready;
    logic PC_Out, PC_In, IncPC, MAR_In, MDR_In, MDR_Read, MDR_Out, IR_In, Y_In;
    logic Zlow_In, Zlow_Out, C_Out, Con_In, InPort_Out, OutPort_In;
    logic G_RA, G_RB, G_RC, R_In, R_Out, BA_Out, Mem_Read, Mem_Write, Run, Illegal;
    logic [4:0] ALU_Op;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR_Out(IR_Out), .CON_FF(CON_FF),
        .Mem_Ready(Mem_Ready), .PC_Out(PC_Out), .PC_In(PC_In), .IncPC(IncPC),
        .MAR_In(MAR_In), .MDR_In(MDR_In), .MDR_Read(MDR_Read), .MDR_Out(MDR_Out),
        .IR_In(IR_In), .Y_In(Y_In), .Zlow_In(Zlow_In), .Zlow_Out(Zlow_Out),
        .C_Out(C_Out), .Con_In(Con_In), .InPort_Out(InPort_Out),
        .OutPort_In(OutPort_In), .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC),
        .R_In(R_In), .R_Out(R_Out), .BA_Out(BA_Out), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .ALU_Op(ALU_Op), .Run(Run), .Illegal(Illegal)
    );

    always #5 clock = ~clock;

    localparam logic [29:0] PCO  = 30'd1 << 29;
    localparam logic [29:0] PCI  = 30'd1 << 28;
    localparam logic [29:0] INC  = 30'd1 << 27;
    localparam logic [29:0] MARI = 30'd1 << 26;
    localparam logic [29:0] MDRI = 30'd1 << 25;
    localparam logic [29:0] MDRR = 30'd1 << 24;
    localparam logic [29:0] MDRO = 30'd1 << 23;
    localparam logic [29:0] IRI  = 30'd1 << 22;
    localparam logic [29:0] YIN  = 30'd1 << 21;
    localparam logic [29:0] ZIN  = 30'd1 << 20;
    localparam logic [29:0] ZOUT = 30'd1 << 19;
    localparam logic [29:0] COUT = 30'd1 << 18;
    localparam logic [29:0] CONI = 30'd1 << 17;
    localparam logic [29:0] INPO = 30'd1 << 16;
    localparam logic [29:0] OUTI = 30'd1 << 15;
    localparam logic [29:0] GRA  = 30'd1 << 14;
    localparam logic [29:0] GRB  = 30'd1 << 13;
    localparam logic [29:0] GRC  = 30'd1 << 12;
    localparam logic [29:0] RIN  = 30'd1 << 11;
    localparam logic [29:0] ROUT = 30'd1 << 10;
    localparam logic [29:0] BAO  = 30'd1 << 9;
    localparam logic [29:0] MRD  = 30'd1 << 8;
    localparam logic [29:0] MWR  = 30'd1 << 7;
    localparam logic [29:0] RUN  = 30'd1 << 6;
    localparam logic [29:0] ILL  = 30'd1 << 5;
    localparam logic [29:0] NONE = 30'd0;

    localparam logic [29:0] E_T0 = RUN | PCO | MARI | INC | ZIN;
    localparam logic [29:0] E_T1 = RUN | ZOUT | PCI | MRD | MDRR | MDRI;
    localparam logic [29:0] E_T2 = RUN | MDRO | IRI;
    localparam logic [29:0] E_AT = RUN | GRB | ROUT | YIN;
    localparam logic [29:0] E_WB = RUN | ZOUT | GRA | RIN;
    localparam logic [29:0] E_A3 = RUN | GRB | BAO | YIN;
    localparam logic [29:0] E_A4 = RUN | COUT | ZIN | 30'd3;

    typedef struct {
        string       nm;
        logic [29:0] e;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [29:0] act_s;
    int          checks = 0;
    int          errors = 0;

    assign act_s = {PC_Out, PC_In, IncPC, MAR_In, MDR_In, MDR_Read, MDR_Out, IR_In,
                    Y_In, Zlow_In, Zlow_Out, C_Out, Con_In, InPort_Out, OutPort_In,
                    G_RA, G_RB, G_RC, R_In, R_Out, BA_Out, Mem_Read, Mem_Write,
                    Run, Illegal, ALU_Op};

    // Monitor: pop one expectation per presented cycle, plus structural invariants.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks = checks + 1;
            if (act_s !== cur.e) begin
                errors = errors + 1;
                $display("FAIL %s: got %h expected %h", cur.nm, act_s, cur.e);
            end
            checks = checks + 1;
            if ((32'(G_RA) + 32'(G_RB) + 32'(G_RC) > 32'd1) ||
                (R_In && (R_Out || BA_Out)) || (Mem_Read && Mem_Write)) begin
                errors = errors + 1;
                $display("FAIL invariant@%s: got %h", cur.nm, act_s);
            end
        end
    end

    task automatic step(input string nm, input logic [29:0] e);
        sb.push_back('{nm, e});
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir);
        IR_Out = ir;
        step("fetch_t0", E_T0);
        step("fetch_t1", E_T1);
        step("fetch_t2", E_T2);
    endtask

    task automatic alu3(input string nm, input logic [31:0] ir, input logic [29:0] t3,
                        input logic [29:0] t4, input logic [29:0] t5);
        fetch(ir);
        step({nm, "_t3"}, t3);
        step({nm, "_t4"}, t4);
        step({nm, "_t5"}, t5);
    endtask

    task automatic one(input string nm, input logic [31:0] ir, input logic [29:0] t3);
        fetch(ir);
        step({nm, "_t3"}, t3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0; IR_Out = 32'h0; CON_FF = 1'b0; Mem_Ready = 1'b1;
        @(posedge clock);
        #1;
        step("reset", NONE);
        clear = 1'b1;
        step("rst_state", NONE);

        alu3("add",  32'h18918000, E_AT, RUN | GRC | ROUT | ZIN | 30'd3, E_WB);
        alu3("sub",  32'h20000000, E_AT, RUN | GRC | ROUT | ZIN | 30'd4, E_WB);
        alu3("or",   32'h30000000, E_AT, RUN | GRC | ROUT | ZIN | 30'd6, E_WB);
        alu3("andi", 32'h68000000, E_AT, RUN | COUT | ZIN | 30'd5, E_WB);
        alu3("ori",  32'h70000000, E_AT, RUN | COUT | ZIN | 30'd6, E_WB);
        alu3("ldi",  32'h08000000, E_A3, E_A4, E_WB);

        // ld with a three-cycle memory wait in T6
        alu3("ld", 32'h01000065, E_A3, E_A4, RUN | ZOUT | MARI);
        Mem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) step("ld_t6_wait", RUN | MRD | MDRR | MDRI);
        Mem_Ready = 1'b1;
        step("ld_t6_done", RUN | MRD | MDRR | MDRI);
        step("ld_t7", RUN | MDRO | GRA | RIN);

        // st: Mem_Ready low in T6 must be ignored, Mem_Write holds in T7
        alu3("st", 32'h11000010, E_A3, E_A4, RUN | ZOUT | MARI);
        Mem_Ready = 1'b0;
        step("st_t6", RUN | GRA | ROUT | MDRI);
        step("st_t7_wait", RUN | MWR);
        step("st_t7_wait", RUN | MWR);
        Mem_Ready = 1'b1;
        step("st_t7_done", RUN | MWR);

        CON_FF = 1'b1;
        alu3("br1", 32'h92800019, RUN | GRA | ROUT | CONI, RUN | PCO | YIN, E_A4 & ~YIN | COUT);
        step("br1_t6", RUN | ZOUT | PCI);
        CON_FF = 1'b0;
        alu3("br0", 32'h92800019, RUN | GRA | ROUT | CONI, RUN | PCO | YIN, RUN | COUT | ZIN | 30'd3);
        step("br0_t6", RUN | ZOUT);

        one("jr",  32'h98000000, RUN | GRA | ROUT | PCI);
        one("in",  32'hA8000000, RUN | INPO | GRA | RIN);
        one("out", 32'hB0000000, RUN | GRA | ROUT | OUTI);
        one("nop", 32'hC0000000, RUN);
        one("illegal", 32'hF8000000, RUN | ILL);
        one("after_illegal", 32'hC0000000, RUN);

        // clear during a T1 memory wait drops everything without a clock edge
        IR_Out = 32'hC0000000;
        Mem_Ready = 1'b0;
        step("wait_t0", E_T0);
        step("wait_t1", E_T1);
        clear = 1'b0;
        step("clear_async", NONE);
        clear = 1'b1;
        Mem_Ready = 1'b1;
        step("rst_after_clear", NONE);
        one("nop2", 32'hC0000000, RUN);

        one("halt", 32'hC8000000, RUN);
        Mem_Ready = 1'b0;
        for (int i = 0; i < 10; i++) step("halt_idle", NONE);
        Mem_Ready = 1'b1;
        clear = 1'b0;
        step("halt_clear", NONE);
        clear = 1'b1;
        step("halt_rst", NONE);
        one("restart", 32'hC0000000, RUN);

        repeat (3) @(posedge clock);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
